jk_bank_sequencer: RTL and testbench

//  Command-driven controller for an external bank of WIDTH posedge JK flip-flops sharing CLK.

---
 rtl/jk_bank_sequencer_if.sv | 36 +++
 rtl/jk_bank_sequencer.sv | 144 ++++++++++++++
 tb/tb_jk_bank_sequencer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/jk_bank_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_sequencer_if
// Description : Bundle of the host command handshake (cmd_valid/cmd_ready,
//               cmd_op, cmd_data), the JK bank drive/feedback (J, K, Q_fb)
//               and the status flags (busy, done, tc).
//               slave  : controller side (jk_bank_sequencer)
//               master : host / bank side
// Revision    : 1.0 - initial release
// ============================================================================
interface jk_bank_sequencer_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [STEP_W-1:0] cmd_data;
    logic [WIDTH-1:0]  Q_fb;
    logic [WIDTH-1:0]  J;
    logic [WIDTH-1:0]  K;
    logic              busy;
    logic              done;
    logic              tc;

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, Q_fb,
        output cmd_ready, J, K, busy, done, tc
    );

    modport master (
        output cmd_valid, cmd_op, cmd_data, Q_fb,
        input  cmd_ready, J, K, busy, done, tc
    );
endinterface
`default_nettype wire

// File: rtl/jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : jk_bank_sequencer
// Description : Command-driven controller for an external bank of WIDTH JK
//               flip-flops. Drives per-bit J/K to load, clear or count the
//               bank up/down N steps, using the bank's Q as feedback.
// Ports       : CLK   - clock shared with the JK bank
//               RST_n - asynchronous active-low reset
//               bus   - command handshake, J/K drive, Q_fb, busy/done/tc
// Revision    : 1.0 - initial release
// ============================================================================
module jk_bank_sequencer #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  wire logic             CLK,
    input  wire logic             RST_n,
    jk_bank_sequencer_if.slave    bus
);

    localparam logic [1:0] c_OP_LOAD  = 2'b00;
    localparam logic [1:0] c_OP_UP    = 2'b01;
    localparam logic [1:0] c_OP_DOWN  = 2'b10;
    localparam logic [1:0] c_OP_CLEAR = 2'b11;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [STEP_W-1:0] r_cnt;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_data;
    logic              w_accept;
    logic [WIDTH-1:0]  w_t_up;
    logic [WIDTH-1:0]  w_t_dn;

    // cmd_ready is high exactly in IDLE, so accept reduces to valid in IDLE.
    assign w_accept = bus.cmd_valid && (r_state == c_ST_IDLE);

    // Toggle masks for a binary count: bit i flips when all lower bits are
    // ones (up) or all zeros (down). Built as a ripple chain of ANDs.
    always_comb begin
        w_t_up    = '0;
        w_t_dn    = '0;
        w_t_up[0] = 1'b1;
        w_t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            w_t_up[i] = w_t_up[i-1] &  bus.Q_fb[i-1];
            w_t_dn[i] = w_t_dn[i-1] & ~bus.Q_fb[i-1];
        end
    end

    // State register
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_accept) begin
                    // A zero-step count has nothing to apply to the bank.
                    if (((bus.cmd_op == c_OP_UP) || (bus.cmd_op == c_OP_DOWN)) &&
                        (bus.cmd_data == '0)) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end
            end
            c_ST_RUN: begin
                if ((r_op == c_OP_LOAD) || (r_op == c_OP_CLEAR)) begin
                    w_state_nxt = c_ST_DONE;
                end else if (r_cnt == STEP_W'(1)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Command latch and remaining-step counter
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_cnt  <= '0;
            r_op   <= c_OP_LOAD;
            r_data <= '0;
        end else if (w_accept) begin
            r_cnt  <= bus.cmd_data;
            r_op   <= bus.cmd_op;
            r_data <= bus.cmd_data[WIDTH-1:0];
        end else if ((r_state == c_ST_RUN) && (r_cnt != '0)) begin
            r_cnt  <= r_cnt - STEP_W'(1);
        end
    end

    // Output logic: J/K/tc depend on registered state and live Q_fb
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.tc        = 1'b0;
        bus.J         = '0;
        bus.K         = '0;
        case (r_state)
            c_ST_IDLE: bus.cmd_ready = 1'b1;
            c_ST_RUN: begin
                bus.busy = 1'b1;
                case (r_op)
                    c_OP_LOAD: begin
                        bus.J = r_data;
                        bus.K = ~r_data;
                    end
                    c_OP_UP: begin
                        bus.J  = w_t_up;
                        bus.K  = w_t_up;
                        bus.tc = &bus.Q_fb;
                    end
                    c_OP_DOWN: begin
                        bus.J  = w_t_dn;
                        bus.K  = w_t_dn;
                        bus.tc = ~|bus.Q_fb;
                    end
                    default: begin
                        bus.K = '1;
                    end
                endcase
            end
            c_ST_DONE: bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_jk_bank_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_jk_bank_sequencer
// Description : Self-checking bench for jk_bank_sequencer with a behavioural
//               JK flip-flop bank closing the J/K -> Q_fb loop.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jk_bank_sequencer;

    localparam int WIDTH  = 4;
    localparam int STEP_W = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    jk_bank_sequencer_if #(.WIDTH(WIDTH), .STEP_W(STEP_W)) bus ();

    jk_bank_sequencer #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .CLK   (clk),
        .RST_n (rst_n),
        .bus   (bus)
    );

    // External JK bank; preset path lets the bench start from a known value
    // while the controller holds J=K=0.
    logic [WIDTH-1:0] bank_q     = '0;
    logic [WIDTH-1:0] preset_val = '0;
    logic             preset_en  = 1'b0;

    always @(posedge clk) begin
        if (preset_en) begin
            bank_q <= preset_val;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({bus.J[i], bus.K[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: ;
                endcase
            end
        end
    end
    assign bus.Q_fb = bank_q;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic preset(input logic [WIDTH-1:0] v);
        @(negedge clk);
        preset_val = v;
        preset_en  = 1'b1;
        @(negedge clk);
        preset_en  = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  data;
        logic [3:0]  q0;
        int          lat;      // cycles from accept edge to done
        int          busy_n;   // RUN cycles
        logic [31:0] tc_mask;  // bit c-1 set when tc seen in RUN cycle c
        logic [3:0]  q_final;
    } vec_t;

    vec_t vecs[9];

    task automatic run_vec(input int idx, input vec_t v);
        int          busy_cnt;
        int          lat;
        logic [31:0] mask;
        busy_cnt = 0;
        lat      = -1;
        mask     = '0;
        preset(v.q0);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = v.op;
        bus.cmd_data  = v.data;
        @(posedge clk);
        #1;
        // Garbage after the accept edge must be ignored.
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = ~v.op;
        bus.cmd_data  = 8'hFF;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.tc && c <= 32) mask[c-1] = 1'b1;
            if (bus.done) begin
                lat = c;
                check($sformatf("v%0d ready_in_done", idx), {31'd0, bus.cmd_ready}, 32'd0);
                break;
            end
        end
        if (lat < 0) $display("FAIL v%0d done_timeout actual=none required=%0d", idx, v.lat);
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d busy_cycles", idx), busy_cnt, v.busy_n);
        check($sformatf("v%0d tc_mask", idx), mask, v.tc_mask);
        @(negedge clk);
        check($sformatf("v%0d ready_after", idx), {31'd0, bus.cmd_ready}, 32'd1);
        check($sformatf("v%0d q_final", idx), {28'd0, bank_q}, {28'd0, v.q_final});
    endtask

    int ready_cnt;
    int ready_pos[8];
    int done_cnt;

    initial begin
        //            op     data   q0    lat busy tc_mask       q_final
        vecs[0] = '{2'b00, 8'h0A, 4'h0,  2,  1, 32'h0000_0000, 4'hA};
        vecs[1] = '{2'b01, 8'd5,  4'hD,  6,  5, 32'h0000_0004, 4'h2};
        vecs[2] = '{2'b10, 8'd3,  4'h1,  4,  3, 32'h0000_0002, 4'hE};
        vecs[3] = '{2'b01, 8'd0,  4'h6,  1,  0, 32'h0000_0000, 4'h6};
        vecs[4] = '{2'b11, 8'h55, 4'h7,  2,  1, 32'h0000_0000, 4'h0};
        vecs[5] = '{2'b10, 8'd0,  4'h9,  1,  0, 32'h0000_0000, 4'h9};
        vecs[6] = '{2'b00, 8'hF3, 4'h5,  2,  1, 32'h0000_0000, 4'h3};
        vecs[7] = '{2'b01, 8'd16, 4'h7, 17, 16, 32'h0000_0100, 4'h7};
        vecs[8] = '{2'b10, 8'd1,  4'h0,  2,  1, 32'h0000_0001, 4'hF};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_busy",  {31'd0, bus.busy},      32'd0);
        check("rst_done",  {31'd0, bus.done},      32'd0);
        check("rst_tc",    {31'd0, bus.tc},        32'd0);
        check("rst_J",     {28'd0, bus.J},         32'd0);
        check("rst_K",     {28'd0, bus.K},         32'd0);
        rst_n = 1'b1;

        // Table-driven commands
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // LOAD 4'hA from 0: J/K drive pattern in the single RUN cycle
        preset(4'h0);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_data = 8'h0A;
        @(posedge clk); #1; bus.cmd_valid = 1'b0;
        @(negedge clk);
        check("load_J", {28'd0, bus.J}, 32'hA);
        check("load_K", {28'd0, bus.K}, 32'h5);
        @(negedge clk);
        check("load_done", {31'd0, bus.done}, 32'd1);
        check("load_JK_idle", {24'd0, bus.J, bus.K}, 32'd0);
        check("load_q", {28'd0, bank_q}, 32'hA);

        // Reset in the middle of UP 10 from 3
        preset(4'h3);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 8'd10;
        @(posedge clk); #1; bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_q_before_rst", {28'd0, bank_q}, 32'h6);
        rst_n = 1'b0;
        #1;
        check("mid_rst_JK", {24'd0, bus.J, bus.K}, 32'd0);
        check("mid_rst_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("mid_rst_done_pulses", done_cnt, 0);
        check("mid_rst_q_frozen", {28'd0, bank_q}, 32'h6);

        // cmd_valid held high: UP 2 accepted every 4 cycles
        preset(4'h0);
        ready_cnt = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b01; bus.cmd_data = 8'd2;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.cmd_ready) begin
                if (ready_cnt < 8) ready_pos[ready_cnt] = c;
                ready_cnt++;
            end
            if (bus.busy) begin
                bus.cmd_op = 2'b11; bus.cmd_data = 8'hC7;
            end else begin
                bus.cmd_op = 2'b01; bus.cmd_data = 8'd2;
            end
        end
        bus.cmd_valid = 1'b0;
        check("hold_up_ready_cnt", ready_cnt, 4);
        check("hold_up_spacing", ready_pos[3] - ready_pos[2], 4);
        check("hold_up_q", {28'd0, bank_q}, 32'h6);
        repeat (6) @(negedge clk);

        // cmd_valid held high: CLEAR accepted every 3 cycles
        preset(4'h5);
        ready_cnt = 0;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b11; bus.cmd_data = 8'd0;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.cmd_ready) begin
                if (ready_cnt < 8) ready_pos[ready_cnt] = c;
                ready_cnt++;
            end
            if (c == 1) check("hold_clr_K", {28'd0, bus.K}, 32'hF);
            if (bus.busy) begin
                bus.cmd_op = 2'b01; bus.cmd_data = 8'd9;
            end else begin
                bus.cmd_op = 2'b11; bus.cmd_data = 8'd0;
            end
        end
        bus.cmd_valid = 1'b0;
        check("hold_clr_ready_cnt", ready_cnt, 4);
        check("hold_clr_spacing", ready_pos[1] - ready_pos[0], 3);
        check("hold_clr_q", {28'd0, bank_q}, 32'h0);
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
